event_indicator: RTL and testbench

//  Output-side companion to the button debouncer. It turns single-cycle event pulses
//  (debounced buttons, entry/exit events, slot-full alarms) into human-visible blink

---
 rtl/event_indicator_pkg.sv | 18 +
 rtl/event_indicator.sv | 139 +++++++++++++
 tb/tb_event_indicator.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/event_indicator_pkg.sv
// Shared timing definitions for the button debouncer and the event indicator.
// All blink and debounce timing derives from the one clock constant below.
package event_indicator_pkg;

   localparam int CLK_FREQUENCY_DEFAULT = 40_000_000;

   // Width of a phase counter that must count 0..max(on_ticks,off_ticks)-1.
   // The result is never narrower than one bit.
   function automatic int phase_counter_width(input int on_ticks, input int off_ticks);
      int longest;
      longest = (on_ticks > off_ticks) ? on_ticks : off_ticks;
      if (longest < 2) begin
         return 1;
      end
      return $clog2(longest);
   endfunction

endpackage

// File: rtl/event_indicator.sv
// Event indicator: turns one-cycle event pulses into visible blink sequences on
// an LED or buzzer pin.
// - A sequence is N blinks, where each blink is one ON phase followed by one OFF phase.
// - Events that arrive while a sequence is running are counted, up to a saturating
//   limit, and replayed back-to-back.
// - Every output is driven directly from a flop.
module event_indicator
   import event_indicator_pkg::*;
#(
   parameter int CLK_FREQUENCY = CLK_FREQUENCY_DEFAULT,
   parameter int ON_HZ         = 4,
   parameter int OFF_HZ        = 4,
   parameter int MAX_PENDING   = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       trig,
   input  logic [3:0] cfg_blinks,
   output logic       led,
   output logic       busy,
   output logic [2:0] pending
);

   localparam int ON_TICKS  = CLK_FREQUENCY / ON_HZ;
   localparam int OFF_TICKS = CLK_FREQUENCY / OFF_HZ;
   localparam int CNT_W     = phase_counter_width(ON_TICKS, OFF_TICKS);

   localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_TICKS - 1);
   localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_TICKS - 1);
   localparam logic [2:0]       PEND_MAX = 3'(MAX_PENDING);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ON   = 2'd1,
      OFF  = 2'd2
   } state_t;

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [3:0]       blinks_left, blinks_n;
   logic [2:0]       pending_n;
   logic             led_n, busy_n;

   logic             on_last, off_last, seq_end;
   logic [3:0]       first_blinks;

   assign on_last      = (cnt == ON_LAST);
   assign off_last     = (cnt == OFF_LAST);
   assign seq_end      = (state == OFF) && off_last && (blinks_left == 4'd0);
   // A cfg_blinks value of 0 behaves like 1. The first blink starts at once,
   // so the counter holds only the remaining blinks.
   assign first_blinks = (cfg_blinks == 4'd0) ? 4'd0 : cfg_blinks - 4'd1;

   // State, phase counter, blink count, queue count and output flops.
   // The asynchronous active-low reset clears all of them immediately.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         cnt         <= '0;
         blinks_left <= 4'd0;
         pending     <= 3'd0;
         led         <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         blinks_left <= blinks_n;
         pending     <= pending_n;
         led         <= led_n;
         busy        <= busy_n;
      end
   end

   // Next-state logic for the phase sequencing and the queue count.
   // - An event that coincides with the sequence-end edge is not queued. It
   //   starts the next sequence directly.
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      blinks_n  = blinks_left;
      pending_n = pending;
      led_n     = led;
      busy_n    = busy;

      if (trig && (state != IDLE) && !seq_end && (pending != PEND_MAX)) begin
         pending_n = pending + 3'd1;
      end

      case (state)
         IDLE: begin
            if (trig) begin
               state_n  = ON;
               cnt_n    = '0;
               blinks_n = first_blinks;
               led_n    = 1'b1;
               busy_n   = 1'b1;
            end
         end
         ON: begin
            if (on_last) begin
               state_n = OFF;
               cnt_n   = '0;
               led_n   = 1'b0;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         OFF: begin
            if (off_last) begin
               cnt_n = '0;
               if (blinks_left != 4'd0) begin
                  state_n  = ON;
                  blinks_n = blinks_left - 4'd1;
                  led_n    = 1'b1;
               end else if ((pending != 3'd0) || trig) begin
                  state_n  = ON;
                  blinks_n = first_blinks;
                  led_n    = 1'b1;
                  if (!trig) begin
                     pending_n = pending - 3'd1;
                  end
               end else begin
                  state_n = IDLE;
                  busy_n  = 1'b0;
               end
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
            led_n   = 1'b0;
            busy_n  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_event_indicator.sv
// Directed bench for event_indicator with ON_TICKS=10 and OFF_TICKS=5.
// - Each blink is 15 cycles: led=1 for cycles 0..9 and led=0 for cycles 10..14,
//   counted from the cycle after the start edge.
// - Inputs change and outputs are sampled on the falling edge.
module tb_event_indicator;

   localparam int CLK_FREQUENCY = 40;
   localparam int ON_HZ         = 4;
   localparam int OFF_HZ        = 8;
   localparam int MAX_PENDING   = 3;

   logic       clk = 1'b0;
   logic       reset;
   logic       trig;
   logic [3:0] cfg_blinks;
   logic       led;
   logic       busy;
   logic [2:0] pending;

   int tests_run    = 0;
   int tests_failed = 0;

   // Free-running clock with a 10-unit period.
   always #5 clk = ~clk;

   event_indicator #(
      .CLK_FREQUENCY(CLK_FREQUENCY),
      .ON_HZ        (ON_HZ),
      .OFF_HZ       (OFF_HZ),
      .MAX_PENDING  (MAX_PENDING)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .trig      (trig),
      .cfg_blinks(cfg_blinks),
      .led       (led),
      .busy      (busy),
      .pending   (pending)
   );

   task automatic applyStimulus(input logic t, input logic [3:0] c);
      trig       = t;
      cfg_blinks = c;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic checkOutput(input string tag, input logic e_led, input logic e_busy,
                              input logic [2:0] e_pend);
      tests_run++;
      assert ({led, busy, pending} === {e_led, e_busy, e_pend}) else begin
         tests_failed++;
         $error("[TB] FAIL %s: led/busy/pending got %b/%b/%0d want %b/%b/%0d",
                tag, led, busy, pending, e_led, e_busy, e_pend);
      end
   endtask

   // Checks sequence cycles [first, last), where cycle 0 follows the start edge.
   // The task returns positioned at cycle 'last'.
   task automatic checkSequence(input string tag, input int first, input int last,
                                input logic [2:0] e_pend);
      for (int c = first; c < last; c++) begin
         checkOutput($sformatf("%s c%0d", tag, c), ((c % 15) < 10), 1'b1, e_pend);
         tick();
      end
   endtask

   initial begin
      reset = 1'b1;
      applyStimulus(1'b0, 4'd0);
      #1 reset = 1'b0;
      @(negedge clk);

      // 1: outputs stay clear while reset is held, then stay clear until a trig arrives
      for (int i = 0; i < 6; i++) begin
         applyStimulus(i[0], 4'd2);
         tick();
         checkOutput("t1 in reset", 1'b0, 1'b0, 3'd0);
      end
      applyStimulus(1'b0, 4'd2);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("t1 idle", 1'b0, 1'b0, 3'd0);
      end

      // 2: a two-blink sequence lasts 30 cycles
      applyStimulus(1'b1, 4'd2);
      tick();
      applyStimulus(1'b0, 4'd2);
      checkSequence("t2", 0, 30, 3'd0);
      checkOutput("t2 end", 1'b0, 1'b0, 3'd0);

      // 3: cfg_blinks=0 gives one blink; the change to 7 mid-sequence is ignored
      applyStimulus(1'b1, 4'd0);
      tick();
      applyStimulus(1'b0, 4'd7);
      checkSequence("t3", 0, 15, 3'd0);
      checkOutput("t3 end", 1'b0, 1'b0, 3'd0);
      tick();
      checkOutput("t3 stay idle", 1'b0, 1'b0, 3'd0);

      // 4: the queue count saturates at 3, then drains over three back-to-back sequences
      applyStimulus(1'b1, 4'd1);
      tick();
      checkOutput("t4 start", 1'b1, 1'b1, 3'd0);
      for (int j = 1; j <= 4; j++) begin
         applyStimulus(1'b1, 4'd1);
         tick();
         checkOutput($sformatf("t4 queue %0d", j), 1'b1, 1'b1, (j > 3) ? 3'd3 : 3'(j));
      end
      applyStimulus(1'b0, 4'd1);
      checkSequence("t4 seq1", 4, 15, 3'd3);
      checkSequence("t4 seq2", 0, 15, 3'd2);
      checkSequence("t4 seq3", 0, 15, 3'd1);
      checkSequence("t4 seq4", 0, 15, 3'd0);
      checkOutput("t4 end", 1'b0, 1'b0, 3'd0);

      // 5: asynchronous reset at ON cycle 4 of blink 2, then a fresh three-blink sequence
      applyStimulus(1'b1, 4'd3);
      tick();
      tick();
      applyStimulus(1'b0, 4'd3);
      checkSequence("t5 pre", 1, 19, 3'd1);
      checkOutput("t5 mid on", 1'b1, 1'b1, 3'd1);
      #2 reset = 1'b0;
      #1 checkOutput("t5 async reset", 1'b0, 1'b0, 3'd0);
      @(negedge clk);
      checkOutput("t5 held reset", 1'b0, 1'b0, 3'd0);
      reset = 1'b1;
      tick();
      checkOutput("t5 after release", 1'b0, 1'b0, 3'd0);
      applyStimulus(1'b1, 4'd3);
      tick();
      applyStimulus(1'b0, 4'd3);
      checkSequence("t5 fresh", 0, 45, 3'd0);
      checkOutput("t5 end", 1'b0, 1'b0, 3'd0);

      // 6a: a trig on the sequence-end edge with an empty queue starts the next
      //     sequence directly, and cfg_blinks is resampled at that edge
      applyStimulus(1'b1, 4'd1);
      tick();
      applyStimulus(1'b0, 4'd1);
      checkSequence("t6a seq1", 0, 14, 3'd0);
      applyStimulus(1'b1, 4'd2);
      tick();
      applyStimulus(1'b0, 4'd2);
      checkSequence("t6a seq2", 0, 30, 3'd0);
      checkOutput("t6a end", 1'b0, 1'b0, 3'd0);

      // 6b: the same trig with two events queued leaves the queue count at 2
      applyStimulus(1'b1, 4'd1);
      tick();
      tick();
      checkOutput("t6b q1", 1'b1, 1'b1, 3'd1);
      tick();
      checkOutput("t6b q2", 1'b1, 1'b1, 3'd2);
      applyStimulus(1'b0, 4'd1);
      checkSequence("t6b seq1", 2, 14, 3'd2);
      applyStimulus(1'b1, 4'd1);
      tick();
      applyStimulus(1'b0, 4'd1);
      checkSequence("t6b seq2", 0, 15, 3'd2);
      checkSequence("t6b seq3", 0, 15, 3'd1);
      checkSequence("t6b seq4", 0, 15, 3'd0);
      checkOutput("t6b end", 1'b0, 1'b0, 3'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
